// File: rtl/lcd_text_reader_if.sv
// Request/result and LCD pin bundle shared by the text reader and whatever drives it.
// slave = the reader itself, master = the requester plus the panel side.
interface lcd_text_reader_if;
  logic         start;
  logic         mode;
  logic         busy;
  logic         done;
  logic [7:0]   status;
  logic [255:0] dump_data;
  logic         LCD_RS;
  logic         LCD_RW;
  logic         LCD_EN;
  logic [7:0]   LCD_DATA_OUT;
  logic         LCD_DATA_OE;
  logic [7:0]   LCD_DATA_IN;

  modport slave (
    input  start, mode, LCD_DATA_IN,
    output busy, done, status, dump_data,
           LCD_RS, LCD_RW, LCD_EN, LCD_DATA_OUT, LCD_DATA_OE
  );

  modport master (
    output start, mode, LCD_DATA_IN,
    input  busy, done, status, dump_data,
           LCD_RS, LCD_RW, LCD_EN, LCD_DATA_OUT, LCD_DATA_OE
  );
endinterface

// File: rtl/lcd_text_reader.sv
// Read-side HD44780 controller: one status read or a full 2x16 DDRAM dump per request.
//
// state | meaning
// IDLE  | bus released, waiting for start
// STAT  | one read access with RS=0 (busy flag + address counter)
// ADDR1 | write 8'h80 to point the address counter at line 1
// RD1   | 16 data reads, line 1 chars 0..15
// ADDR2 | write 8'hC0 to point the address counter at line 2
// RD2   | 16 data reads, line 2 chars 0..15
// FIN   | one cycle: done pulse, results published
module lcd_text_reader #(
  parameter int T_SETUP = 200,
  parameter int T_EN    = 1600,
  parameter int T_HOLD  = 200
) (
  input logic              LCDCLK,
  input logic              PRESETn,
  lcd_text_reader_if.slave bus
);

  localparam int T_ACC = T_SETUP + T_EN + T_HOLD;
  localparam int PH_W  = $clog2(T_ACC);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(T_ACC - 1);
  localparam logic [PH_W-1:0] PH_EN_ON = PH_W'(T_SETUP);
  localparam logic [PH_W-1:0] PH_CAP   = PH_W'(T_SETUP + T_EN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STAT, S_ADDR1, S_RD1, S_ADDR2, S_RD2, S_FIN
  } state_t;

  state_t        r_state;
  logic [PH_W-1:0] r_ph;
  logic [3:0]    r_idx;
  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_status;
  logic [7:0]    r_cap;
  logic [255:0]  r_dump;
  logic [255:0]  r_shadow;
  logic          r_rs;
  logic          r_rw;
  logic          r_en;
  logic [7:0]    r_dout;
  logic          r_oe;

  logic [PH_W-1:0] w_ph_next;
  logic            w_en_next;
  logic [7:0]      w_sh_hi;

  assign w_ph_next = (r_ph == PH_LAST) ? '0 : r_ph + PH_W'(1);
  assign w_en_next = (w_ph_next >= PH_EN_ON) && (w_ph_next <= PH_CAP);
  // Line 2 chars sit directly below line 1 in the shadow, so line select is the index MSB.
  assign w_sh_hi   = 8'd255 - {(r_state == S_RD2), r_idx, 3'b000};

  always_ff @(posedge LCDCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= S_IDLE;
      r_ph     <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_status <= '0;
      r_cap    <= '0;
      r_dump   <= '0;
      r_shadow <= '0;
      r_rs     <= 1'b0;
      r_rw     <= 1'b0;
      r_en     <= 1'b0;
      r_dout   <= '0;
      r_oe     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_FIN: begin
          r_rs   <= 1'b0;
          r_rw   <= 1'b0;
          r_en   <= 1'b0;
          r_oe   <= 1'b0;
          r_busy <= 1'b0;
          r_ph   <= '0;
          r_idx  <= '0;
          r_state <= S_IDLE;
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.mode) begin
              r_state <= S_ADDR1;
              r_oe    <= 1'b1;
              r_dout  <= 8'h80;
            end else begin
              r_state <= S_STAT;
              r_rw    <= 1'b1;
              r_dout  <= 8'h00;
            end
          end
        end
        default: begin
          r_en <= w_en_next;
          r_ph <= w_ph_next;
          if (r_ph == PH_CAP) begin
            if (r_state == S_STAT)
              r_cap <= bus.LCD_DATA_IN;
            else if (r_state == S_RD1 || r_state == S_RD2)
              r_shadow[w_sh_hi -: 8] <= bus.LCD_DATA_IN;
          end
          if (r_ph == PH_LAST) begin
            case (r_state)
              S_STAT: begin
                r_state  <= S_FIN;
                r_status <= r_cap;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_rs     <= 1'b0;
                r_rw     <= 1'b0;
                r_oe     <= 1'b0;
              end
              S_ADDR1, S_ADDR2: begin
                r_state <= (r_state == S_ADDR1) ? S_RD1 : S_RD2;
                r_idx   <= '0;
                r_rs    <= 1'b1;
                r_rw    <= 1'b1;
                r_oe    <= 1'b0;
                r_dout  <= 8'h00;
              end
              S_RD1: begin
                r_idx <= r_idx + 4'd1;
                if (r_idx == 4'd15) begin
                  r_state <= S_ADDR2;
                  r_rs    <= 1'b0;
                  r_rw    <= 1'b0;
                  r_oe    <= 1'b1;
                  r_dout  <= 8'hC0;
                end
              end
              S_RD2: begin
                r_idx <= r_idx + 4'd1;
                if (r_idx == 4'd15) begin
                  r_state <= S_FIN;
                  r_dump  <= r_shadow;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_rs    <= 1'b0;
                  r_rw    <= 1'b0;
                  r_oe    <= 1'b0;
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.status       = r_status;
  assign bus.dump_data    = r_dump;
  assign bus.LCD_RS       = r_rs;
  assign bus.LCD_RW       = r_rw;
  assign bus.LCD_EN       = r_en;
  assign bus.LCD_DATA_OUT = r_dout;
  assign bus.LCD_DATA_OE  = r_oe;

endmodule

// File: tb/tb_lcd_text_reader.sv
// Bench for lcd_text_reader: panel model answers reads per RS, scoreboard checks each done pulse.
module tb_lcd_text_reader;
  localparam int T_SETUP  = 2;
  localparam int T_EN     = 4;
  localparam int T_HOLD   = 2;
  localparam int T_ACC    = T_SETUP + T_EN + T_HOLD;
  localparam int LAT_STAT = 1 + T_ACC;
  localparam int LAT_DUMP = 1 + 34 * T_ACC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lcd_text_reader_if bus ();

  lcd_text_reader #(
    .T_SETUP (T_SETUP),
    .T_EN    (T_EN),
    .T_HOLD  (T_HOLD)
  ) dut (
    .LCDCLK  (clk),
    .PRESETn (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    logic [7:0]   st;
    logic [255:0] dmp;
    int           c0;
  } exp_t;

  typedef struct {
    logic       rs;
    logic       rw;
    logic       oe;
    logic [7:0] dout;
    int         w;
  } acc_t;

  exp_t sb_q[$];
  acc_t acc_log[$];

  int n_chk    = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int en_rises = 0;
  int en_w     = 0;
  int done_cnt = 0;
  logic en_prev = 1'b0;

  logic [127:0] line1;
  logic [127:0] line2;
  logic [7:0]   m_stat;
  logic [6:0]   m_addr;
  logic [7:0]   exp_status;
  logic [255:0] exp_dump;

  task automatic chk(input string tag, input logic [279:0] act, input logic [279:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [277:0] all_outs();
    return {bus.busy, bus.done, bus.status, bus.dump_data, bus.LCD_RS, bus.LCD_RW,
            bus.LCD_EN, bus.LCD_DATA_OUT, bus.LCD_DATA_OE};
  endfunction

  function automatic logic [7:0] ddram_rd(input logic [6:0] a);
    logic [127:0] l;
    int hi;
    l  = a[6] ? line2 : line1;
    hi = 127 - 8 * int'(a[3:0]);
    return l[hi -: 8];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Panel model, access monitor and scoreboard, all sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      en_prev = 1'b0;
      en_w    = 0;
    end else begin
      if (bus.LCD_EN) en_w++;
      if (bus.LCD_EN && !en_prev) en_rises++;
      if (en_prev && !bus.LCD_EN) begin
        acc_log.push_back('{bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA_OE, bus.LCD_DATA_OUT, en_w});
        chk("en_width", 280'(en_w), 280'(T_EN));
        chk("rw_oe_excl", 280'(bus.LCD_RW & bus.LCD_DATA_OE), 280'(0));
        if (!bus.LCD_RW && !bus.LCD_RS && bus.LCD_DATA_OUT[7])
          m_addr = bus.LCD_DATA_OUT[6:0];
        else if (bus.LCD_RW && bus.LCD_RS)
          m_addr = m_addr + 7'd1;
        en_w = 0;
      end
      en_prev = bus.LCD_EN;
      if (bus.done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 280'(bus.done), 280'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("latency", 280'(cyc - e.c0), 280'(e.mode ? LAT_DUMP : LAT_STAT));
          chk("status", 280'(bus.status), 280'(e.st));
          chk("dump_data", 280'(bus.dump_data), 280'(e.dmp));
          chk("busy_at_done", 280'(bus.busy), 280'(0));
        end
      end
    end
    bus.LCD_DATA_IN = bus.LCD_RS ? ddram_rd(m_addr) : m_stat;
  end

  task automatic start_op(input logic m, input logic accept);
    bus.mode  = m;
    bus.start = 1'b1;
    if (accept) begin
      if (m) exp_dump = {line1, line2};
      else   exp_status = m_stat;
      sb_q.push_back('{m, exp_status, exp_dump, cyc});
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 280'(sb_q.size()), 280'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int d0;
    bus.start      = 1'b0;
    bus.mode       = 1'b0;
    bus.LCD_DATA_IN = 8'h00;
    m_stat     = 8'h8A;
    m_addr     = 7'd0;
    line1      = "HELLO WORLD     ";
    line2      = "LCD READ TEST   ";
    exp_status = 8'h00;
    exp_dump   = '0;
    rst_n      = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outs", 280'(all_outs()), 280'(0));
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_outs", 280'(all_outs()), 280'(0));
    chk("idle_en_rises", 280'(en_rises), 280'(0));

    // Status read
    acc_log.delete();
    start_op(1'b0, 1'b1);
    wait_idle(50, "status_timeout");
    chk("status_nacc", 280'(acc_log.size()), 280'(1));
    if (acc_log.size() >= 1)
      chk("status_rs_rw_oe", 280'({acc_log[0].rs, acc_log[0].rw, acc_log[0].oe}), 280'(3'b010));

    // Full dump
    repeat (3) @(negedge clk);
    acc_log.delete();
    start_op(1'b1, 1'b1);
    wait_idle(400, "dump_timeout");
    chk("dump_nacc", 280'(acc_log.size()), 280'(34));
    if (acc_log.size() == 34) begin
      chk("wr_line1", 280'({acc_log[0].rs, acc_log[0].rw, acc_log[0].oe, acc_log[0].dout}),
          280'({3'b001, 8'h80}));
      chk("wr_line2", 280'({acc_log[17].rs, acc_log[17].rw, acc_log[17].oe, acc_log[17].dout}),
          280'({3'b001, 8'hC0}));
      for (int k = 0; k < 34; k++)
        if (k != 0 && k != 17)
          chk("rd_rs_rw_oe", 280'({acc_log[k].rs, acc_log[k].rw, acc_log[k].oe}), 280'(3'b110));
    end
    chk("dump_char_H", 280'(bus.dump_data[255:248]), 280'(8'h48));
    chk("dump_char_L", 280'(bus.dump_data[127:120]), 280'(8'h4C));

    // start while busy is ignored
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    start_op(1'b1, 1'b1);
    repeat (4) @(negedge clk);
    start_op(1'b0, 1'b0);
    chk("busy_during_dump", 280'(bus.busy), 280'(1));
    wait_idle(400, "busy_timeout");
    repeat (20) @(negedge clk);
    chk("busy_single_done", 280'(done_cnt - d0), 280'(1));

    // Reset in the middle of the 7th data read, then a fresh dump
    line1 = "ABCDEFGHIJKLMNOP";
    line2 = "0123456789abcdef";
    acc_log.delete();
    start_op(1'b1, 1'b1);
    i = 0;
    while (acc_log.size() < 7 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("rst7_reached", 280'(acc_log.size() >= 7), 280'(1));
    repeat (5) @(negedge clk);
    chk("rst_mid_en_high", 280'(bus.LCD_EN), 280'(1));
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_outs", 280'(all_outs()), 280'(0));
    sb_q.delete();
    exp_status = 8'h00;
    exp_dump   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_partial", 280'(bus.dump_data), 280'(0));
    acc_log.delete();
    start_op(1'b1, 1'b1);
    wait_idle(400, "redump_timeout");
    chk("redump_char_A", 280'(bus.dump_data[255:248]), 280'(8'h41));

    // Back-to-back status reads, second start in the FIN cycle
    repeat (2) @(negedge clk);
    m_stat = 8'h8A;
    start_op(1'b0, 1'b1);
    i = 0;
    while (!bus.done && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("b2b_done_seen", 280'(bus.done), 280'(1));
    m_stat = 8'h35;
    start_op(1'b0, 1'b1);
    chk("b2b_no_merge", 280'(bus.done), 280'(0));
    chk("b2b_busy", 280'(bus.busy), 280'(1));
    wait_idle(50, "b2b_timeout");
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
